// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage feeder: FP32 constants, FSM encoding,
// the N=16 twiddle table and a bit-reverse helper.
package fft_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  localparam int TW_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FULL  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // exp(-j*2*pi*i/16) for i = 0..7
  localparam logic [31:0] TW_RE [TW_DEPTH] = '{
    FP_ONE,       32'h3F6C835E, 32'h3F3504F3, 32'h3EC3EF15,
    FP_ZERO,      32'hBEC3EF15, 32'hBF3504F3, 32'hBF6C835E
  };
  localparam logic [31:0] TW_IM [TW_DEPTH] = '{
    FP_ZERO,      32'hBEC3EF15, 32'hBF3504F3, 32'hBF6C835E,
    32'hBF800000, 32'hBF6C835E, 32'hBF3504F3, 32'hBEC3EF15
  };

  // Reverses the low 'bits' bits of v; upper bits of the result are zero.
  function automatic logic [3:0] bit_rev(input logic [3:0] v, input int bits);
    logic [3:0] r;
    logic [3:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (i < bits) begin
        r = {r[2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle ROM: 3-bit index into the N=16 half-circle table.
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  logic [2:0]  i_idx,
  output logic [31:0] o_w_real,
  output logic [31:0] o_w_imag
);

  assign o_w_real = TW_RE[i_idx];
  assign o_w_imag = TW_IM[i_idx];

endmodule

// File: rtl/fft_stage_feeder.sv
// Buffers one N-point complex FP32 block and issues the N/2 radix-2 DIT operand
// sets of one stage per command. Optional macro FFT_FEEDER_BITREV_LOAD_EN.
module fft_stage_feeder
  import fft_pkg::*;
#(
  parameter int LOG2N = 3,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_real,
  input  logic [DW-1:0]    in_imag,
  input  logic             start,
  input  logic [1:0]       stage,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  output logic [DW-1:0]    x_real,
  output logic [DW-1:0]    x_imag,
  output logic [DW-1:0]    y_real,
  output logic [DW-1:0]    y_imag,
  output logic [DW-1:0]    w_real,
  output logic [DW-1:0]    w_imag,
  output logic [LOG2N-1:0] idx_top,
  output logic [LOG2N-1:0] idx_bot
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int AW   = LOG2N;

  state_e          r_state;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   r_k;
  logic [1:0]      r_stage;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_bf_valid;
  logic [DW-1:0]   r_x_re, r_x_im, r_y_re, r_y_im, r_w_re, r_w_im;
  logic [AW-1:0]   r_top, r_bot;

  logic [DW-1:0]   r_buf_re [N];
  logic [DW-1:0]   r_buf_im [N];

  logic [1:0]      w_stage;
  logic [AW-1:0]   w_k, w_span, w_j, w_top, w_bot;
  logic [2:0]      w_sh;
  logic [3:0]      w_j4;
  logic [2:0]      w_tw_idx;
  logic [31:0]     w_tw_re, w_tw_im;
  logic            w_stage_ok;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_addr;

`ifdef FFT_FEEDER_BITREV_LOAD_EN
  assign w_wr_addr = AW'(bit_rev(4'(r_cnt), LOG2N));
`else
  assign w_wr_addr = r_cnt;
`endif

  assign w_wr_en    = (r_state == ST_LOAD) && in_valid;
  assign w_stage_ok = 32'(stage) < LOG2N;

  // In FULL the first set is addressed from the command inputs so that it is
  // registered on the start edge; in ISSUE the latched stage and k take over.
  always_comb begin
    w_stage  = (r_state == ST_ISSUE) ? r_stage : stage;
    w_k      = (r_state == ST_ISSUE) ? r_k : '0;
    w_span   = AW'(1) << w_stage;
    w_j      = w_k & (w_span - AW'(1));
    w_sh     = {1'b0, w_stage} + 3'd1;
    w_top    = ((w_k >> w_stage) << w_sh) | w_j;
    w_bot    = w_top | w_span;
    w_j4     = 4'(w_j);
    w_tw_idx = 3'(w_j4 << (2'd3 - w_stage));
  end

  fft_twiddle_rom u_rom (
    .i_idx    (w_tw_idx),
    .o_w_real (w_tw_re),
    .o_w_imag (w_tw_im)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf_re[w_wr_addr] <= in_real;
      r_buf_im[w_wr_addr] <= in_imag;
    end
  end

  // state    | meaning
  // ST_LOAD  | accepting samples into the buffer, cnt = next sample number
  // ST_FULL  | block captured, waiting for a legal start command
  // ST_ISSUE | one operand set per cycle, done with the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_LOAD;
      r_cnt      <= '0;
      r_k        <= '0;
      r_stage    <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bf_valid <= 1'b0;
      r_x_re     <= '0;
      r_x_im     <= '0;
      r_y_re     <= '0;
      r_y_im     <= '0;
      r_w_re     <= '0;
      r_w_im     <= '0;
      r_top      <= '0;
      r_bot      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            if (r_cnt == AW'(N - 1)) begin
              r_cnt      <= '0;
              r_state    <= ST_FULL;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + AW'(1);
            end
          end
        end
        ST_FULL: begin
          if (start && w_stage_ok) begin
            r_state    <= ST_ISSUE;
            r_stage    <= stage;
            r_k        <= AW'(1);
            r_busy     <= 1'b1;
            r_bf_valid <= 1'b1;
            r_done     <= (HALF == 1);
            r_x_re     <= r_buf_re[w_top];
            r_x_im     <= r_buf_im[w_top];
            r_y_re     <= r_buf_re[w_bot];
            r_y_im     <= r_buf_im[w_bot];
            r_w_re     <= w_tw_re;
            r_w_im     <= w_tw_im;
            r_top      <= w_top;
            r_bot      <= w_bot;
          end
        end
        ST_ISSUE: begin
          // r_done marks that the set now on the outputs is the last one
          if (r_done) begin
            r_state    <= ST_LOAD;
            r_busy     <= 1'b0;
            r_bf_valid <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_k        <= r_k + AW'(1);
            r_done     <= (r_k == AW'(HALF - 1));
            r_x_re     <= r_buf_re[w_top];
            r_x_im     <= r_buf_im[w_top];
            r_y_re     <= r_buf_re[w_bot];
            r_y_im     <= r_buf_im[w_bot];
            r_w_re     <= w_tw_re;
            r_w_im     <= w_tw_im;
            r_top      <= w_top;
            r_bot      <= w_bot;
          end
        end
        default: begin
          r_state    <= ST_LOAD;
          r_cnt      <= '0;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_bf_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign bf_valid = r_bf_valid;
  assign x_real   = r_x_re;
  assign x_imag   = r_x_im;
  assign y_real   = r_y_re;
  assign y_imag   = r_y_im;
  assign w_real   = r_w_re;
  assign w_imag   = r_w_im;
  assign idx_top  = r_top;
  assign idx_bot  = r_bot;

endmodule

// File: tb/tb_fft_stage_feeder.sv
// Directed bench for fft_stage_feeder (LOG2N=3): table of expected operand sets
// per stage plus hand sequences for reset, illegal stage and stray commands.
module tb_fft_stage_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_real, in_imag;
  logic        start;
  logic [1:0]  stage;
  logic        busy, done, bf_valid;
  logic [31:0] x_real, x_imag, y_real, y_imag, w_real, w_imag;
  logic [2:0]  idx_top, idx_bot;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fft_stage_feeder #(.LOG2N(3), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .start    (start),
    .stage    (stage),
    .busy     (busy),
    .done     (done),
    .bf_valid (bf_valid),
    .x_real   (x_real),
    .x_imag   (x_imag),
    .y_real   (y_real),
    .y_imag   (y_imag),
    .w_real   (w_real),
    .w_imag   (w_imag),
    .idx_top  (idx_top),
    .idx_bot  (idx_bot)
  );

  typedef struct {
    logic [1:0] stg;
    int         top;
    int         bot;
    int         tw;
    logic       last;
  } vec_t;

  vec_t        vt [12];
  logic [31:0] flt [8];
  logic [31:0] twr [8];
  logic [31:0] twi [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int br3(input int a);
    logic [2:0] v;
    v = 3'(a);
    return int'({v[0], v[1], v[2]});
  endfunction

  // Sample value expected in buffer location a.
  function automatic logic [31:0] smp(input int a);
`ifdef FFT_FEEDER_BITREV_LOAD_EN
    return flt[br3(a)];
`else
    return flt[a];
`endif
  endfunction

  task automatic load_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      chk("load_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_real  = flt[i];
      in_imag  = 32'h0;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_issue(input int base, input bit hold_start);
    start = 1'b1;
    stage = vt[base].stg;
    tick();
    if (hold_start) stage = 2'd2;
    else start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v = vt[base + i];
      chk("bf_valid", 32'(bf_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("idx_top", 32'(idx_top), 32'(v.top));
      chk("idx_bot", 32'(idx_bot), 32'(v.bot));
      chk("x_real", x_real, smp(v.top));
      chk("x_imag", x_imag, 32'h0);
      chk("y_real", y_real, smp(v.bot));
      chk("y_imag", y_imag, 32'h0);
      chk("w_real", w_real, twr[v.tw]);
      chk("w_imag", w_imag, twi[v.tw]);
      chk("done", 32'(done), 32'(v.last));
      tick();
    end
    start = 1'b0;
    chk("post_bf_valid", 32'(bf_valid), 32'd0);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("hold_idx_top", 32'(idx_top), 32'(vt[base + 3].top));
    chk("hold_y_real", y_real, smp(vt[base + 3].bot));
  endtask

  initial begin
    flt = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
            32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
    twr = '{32'h3F800000, 32'h3F6C835E, 32'h3F3504F3, 32'h3EC3EF15,
            32'h00000000, 32'hBEC3EF15, 32'hBF3504F3, 32'hBF6C835E};
    twi = '{32'h00000000, 32'hBEC3EF15, 32'hBF3504F3, 32'hBF6C835E,
            32'hBF800000, 32'hBF6C835E, 32'hBF3504F3, 32'hBEC3EF15};
    // stage 0
    vt[0]  = '{2'd0, 0, 1, 0, 1'b0};
    vt[1]  = '{2'd0, 2, 3, 0, 1'b0};
    vt[2]  = '{2'd0, 4, 5, 0, 1'b0};
    vt[3]  = '{2'd0, 6, 7, 0, 1'b1};
    // stage 1: t = j<<1, ROM index = t<<1
    vt[4]  = '{2'd1, 0, 2, 0, 1'b0};
    vt[5]  = '{2'd1, 1, 3, 4, 1'b0};
    vt[6]  = '{2'd1, 4, 6, 0, 1'b0};
    vt[7]  = '{2'd1, 5, 7, 4, 1'b1};
    // stage 2: t = j, ROM index = t<<1
    vt[8]  = '{2'd2, 0, 4, 0, 1'b0};
    vt[9]  = '{2'd2, 1, 5, 2, 1'b0};
    vt[10] = '{2'd2, 2, 6, 4, 1'b0};
    vt[11] = '{2'd2, 3, 7, 6, 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_real  = '0;
    in_imag  = '0;
    start    = 1'b0;
    stage    = '0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bf_valid", 32'(bf_valid), 32'd0);
    chk("rst_x_real", x_real, 32'h0);
    chk("rst_w_real", w_real, 32'h0);
    chk("rst_idx_bot", 32'(idx_bot), 32'd0);
    rst = 1'b0;

    // full load, then a 9th sample that must not be consumed
    load_range(0, 7);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_real  = 32'hDEADBEEF;
    in_imag  = 32'hDEADBEEF;
    tick();
    tick();
    chk("extra_in_ready", 32'(in_ready), 32'd0);
    chk("extra_bf_valid", 32'(bf_valid), 32'd0);
    in_valid = 1'b0;
    run_issue(0, 1'b1);

    // illegal stage in FULL is ignored, then stage 2 issues normally
    load_range(0, 7);
    start = 1'b1;
    stage = 2'd3;
    tick();
    start = 1'b0;
    chk("bad_stage_bf_valid", 32'(bf_valid), 32'd0);
    chk("bad_stage_busy", 32'(busy), 32'd0);
    tick();
    chk("bad_stage_bf_valid2", 32'(bf_valid), 32'd0);
    chk("bad_stage_in_ready", 32'(in_ready), 32'd0);
    run_issue(8, 1'b0);

    load_range(0, 7);
    run_issue(4, 1'b0);

    // start during a partial load is ignored and the count carries on
    load_range(0, 4);
    start = 1'b1;
    stage = 2'd0;
    tick();
    start = 1'b0;
    chk("load_start_bf_valid", 32'(bf_valid), 32'd0);
    chk("load_start_busy", 32'(busy), 32'd0);
    chk("load_start_in_ready", 32'(in_ready), 32'd1);
    load_range(5, 7);
    chk("split_full_in_ready", 32'(in_ready), 32'd0);
    run_issue(8, 1'b0);

    // reset during the 2nd issue cycle
    load_range(0, 7);
    start = 1'b1;
    stage = 2'd0;
    tick();
    start = 1'b0;
    chk("pre_rst_bf_valid", 32'(bf_valid), 32'd1);
    tick();
    chk("pre_rst_idx_top", 32'(idx_top), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_bf_valid", 32'(bf_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_x_real", x_real, 32'h0);
    chk("mid_rst_idx_bot", 32'(idx_bot), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("after_rst_quiet", 32'({done, bf_valid}), 32'd0);
      tick();
    end
    load_range(0, 6);
    chk("reload_7_in_ready", 32'(in_ready), 32'd1);
    load_range(7, 7);
    chk("reload_full_in_ready", 32'(in_ready), 32'd0);
    run_issue(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fft_stage_feeder.md
Name: fft_stage_feeder

Overview:
- Operand-issue stage directly upstream of the radix-2 FP32 butterfly.
- Captures one N-point block of complex FP32 samples from a valid/ready stream into a local buffer.
- On command, issues the N/2 decimation-in-time butterfly operand sets (X, Y, W) for one selected stage, one per cycle, with twiddles from an internal ROM.
- Tags each set with its top and bottom buffer indices so a downstream writeback can place results.

Parameters:
- LOG2N, 3, log2 of FFT size N; legal range 1..4 (N = 2..16).
- DW, 32, sample word width; fixed IEEE-754 single precision.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  feeder can accept a sample.
- in_real  in  DW  input sample, real part.
- in_imag  in  DW  input sample, imaginary part.
- start  in  1  issue-command strobe.
- stage  in  2  stage to issue, 0..LOG2N-1.
- busy  out  1  high in ISSUE.
- done  out  1  one-cycle pulse with the last operand set.
- bf_valid  out  1  operand set valid.
- x_real, x_imag, y_real, y_imag, w_real, w_imag  out  DW each  butterfly operands.
- idx_top, idx_bot  out  LOG2N each  buffer indices of X and Y.

Behaviour:
- States: LOAD, FULL, ISSUE.
- Reset: state LOAD, load count 0, in_ready=1, busy=0, done=0, bf_valid=0. All operand and index outputs are 0.
- LOAD:
  - in_ready=1.
  - A sample is accepted on any edge with in_valid=1; it is written at address cnt, then cnt increments.
  - After the N-th accept, go to FULL and drop in_ready on the next cycle.
  - start is ignored in LOAD.
- FULL:
  - in_ready=0.
  - start=1 with stage<LOG2N latches stage s, clears k, and enters ISSUE.
  - start with stage>=LOG2N is ignored and the state stays FULL.
- ISSUE, for k = 0..N/2-1, one per cycle:
  - span = 2^s, j = k mod span.
  - top = (k>>s)*2*span + j, bot = top+span.
  - Twiddle index t = j << (LOG2N-1-s); W = exp(-j*2*pi*t/N).
  - Outputs are registered. bf_valid is high for exactly N/2 consecutive cycles, beginning the cycle after the start edge. There are no gaps and no backpressure, because the butterfly is fully pipelined.
  - done=1 in the same cycle as the last bf_valid. The next state is LOAD with cnt=0, so the buffer is released.
- bf_valid=0 outputs: operand and index outputs hold their last values; consumers qualify them with bf_valid.
- start during ISSUE: ignored.
- in_valid in FULL or ISSUE: ignored and not consumed.
- rst mid-LOAD or mid-ISSUE: takes effect on the next edge with the reset values above. Partial loads are discarded; no further bf_valid or done.
- Buffer: N x 2DW registers, one write port and two combinational read ports.
- ROM:
  - 8-entry table for N=16, indexed by t<<(4-LOG2N).
  - Entries (w_real, w_imag) in hex:
    - 0: 3F800000,00000000
    - 1: 3F6C835E,BEC3EF15
    - 2: 3F3504F3,BF3504F3
    - 3: 3EC3EF15,BF6C835E
    - 4: 00000000,BF800000
    - 5: BEC3EF15,BF6C835E
    - 6: BF3504F3,BF3504F3
    - 7: BF6C835E,BEC3EF15

Optional Feature:
- Macro: FFT_FEEDER_BITREV_LOAD_EN.
- Defined: sample number cnt is written at the bit-reversed address (LOG2N bits). The buffer then holds bit-reversed order, and the stage sequence 0..LOG2N-1 yields natural-order output.
- Undefined: the write address is cnt (natural order), and a downstream reorder is required.
- Issue logic is identical in both cases.

Decomposition:
- Shared package fft_pkg:
  - FP32 constants (FP_ONE=3F800000, FP_ZERO).
  - State encoding (LOAD, FULL, ISSUE).
  - Twiddle ROM table constants.
  - Bit-reverse function.
- Sub-module fft_twiddle_rom: combinational, 3-bit index in, w_real/w_imag out. It is instantiated once; the feeder registers its output together with the X/Y reads.

Test Plan:
- Reset then LOAD, LOG2N=3: send samples k=(k.0,0.0) for k=0..7 → in_ready=1 for 8 accepts, then 0. A 9th in_valid is not consumed.
- Stage 0 issue → 4 consecutive bf_valid cycles:
  - Pairs (0,1),(2,3),(4,5),(6,7); all W=(3F800000,00000000).
  - First set x=(0,0), y=(1.0,0); done coincides with the 4th cycle.
- Stage 2 issue after reload → pairs (0,4),(1,5),(2,6),(3,7). W indices 0,2,4,6 map to 3F800000/00000000, 3F3504F3/BF3504F3, 00000000/BF800000, BF3504F3/BF3504F3.
- Corner commands:
  - start with stage=3 in FULL → no bf_valid, state stays FULL.
  - start during LOAD (5 samples) → ignored.
- rst asserted on the 2nd ISSUE cycle → next cycle bf_valid=0, done never pulses, in_ready=1, cnt restarts at 0.
- With FFT_FEEDER_BITREV_LOAD_EN: load k=0..7, stage 0 → first set x=(0.0,0), y=(4.0,0), idx_top=0, idx_bot=1.
